// File: rtl/byte_serial_adder.sv
// Byte-serial multi-byte adder: streams NBYTES-wide operands through one 8-bit
// carry-select slice, LSB byte first. Optional signed overflow flag: SERIAL_ADD_OVF_EN.
module byte_serial_adder #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned SW = IW + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry;
    logic [IW-1:0]   idx;

    logic            accept_c;
    logic            last_c;
    logic [SW-1:0]   lane_c;
    logic [7:0]      byte_a_c;
    logic [7:0]      byte_b_c;
    logic [4:0]      lo_c;
    logic [4:0]      hi0_c;
    logic [4:0]      hi1_c;
    logic [7:0]      add_sum_c;
    logic            add_cout_c;

    // State register; busy/done are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ADD);
            done  <= (state_nxt == DONE);
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (idx == IW'(NBYTES - 1)) state_nxt = DONE;
            DONE:    state_nxt = start ? ADD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath control and the 8-bit carry-select byte slice
    always_comb begin
        accept_c   = start && ((state == IDLE) || (state == DONE));
        last_c     = (state == ADD) && (idx == IW'(NBYTES - 1));
        lane_c     = {idx, 3'b000};
        byte_a_c   = 8'(a_r >> lane_c);
        byte_b_c   = 8'(b_r >> lane_c);
        lo_c       = {1'b0, byte_a_c[3:0]} + {1'b0, byte_b_c[3:0]} + {4'b0000, carry};
        hi0_c      = {1'b0, byte_a_c[7:4]} + {1'b0, byte_b_c[7:4]};
        hi1_c      = hi0_c + 5'd1;
        add_sum_c  = {(lo_c[4] ? hi1_c[3:0] : hi0_c[3:0]), lo_c[3:0]};
        add_cout_c = lo_c[4] ? hi1_c[4] : hi0_c[4];
    end

    // Operand capture, byte-lane result write and carry ripple
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept_c) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == ADD) begin
            sum[lane_c +: 8] <= add_sum_c;
            carry            <= add_cout_c;
            if (last_c) begin
                cout <= add_cout_c;
`ifdef SERIAL_ADD_OVF_EN
                ovf  <= (a_r[W-1] == b_r[W-1]) && (add_sum_c[7] != a_r[W-1]);
`endif
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule
